clk_edge_meter: RTL and testbench
=================================

# clk_edge_meter

Receiving end of the divided-clock path: takes a slow, free-running square wave (such as a divider output), synchronises it into the `clk_in` domain, and produces single-cycle rising and falling tick pulses. Logic downstream uses these ticks as clock enables instead of clocking registers from the slow signal. It also measures the rising-edge period in `clk_in` cycles and delivers each measurement over a valid/ready handshake, with overrun and timeout flags.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flops on `slow_in`; legal values are 2 or more.
- `CNT_BITS`, default 26: width of the period counter and of `period`.
- `clk_in`  in  1: the only clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `slow_in`  in  1: slow square wave; may be asynchronous to `clk_in`.
- `level`  out  1: synchronised level of `slow_in`.
- `tick_rise`  out  1: one-cycle pulse per rising edge of `slow_in`.
- `tick_fall`  out  1: one-cycle pulse per falling edge of `slow_in`.
- `period`  out  CNT_BITS: `clk_in` cycles between the last two `tick_rise` pulses.
- `period_valid`  out  1: `period` holds an unconsumed measurement.
- `period_ready`  in  1: consumer accepts the measurement.
- `overrun`  out  1: sticky; a measurement arrived while the previous one was unconsumed.
- `timeout`  out  1: the counter saturated without seeing a rising edge.

## Operation
- **Synchroniser.** A chain of `SYNC_STAGES` flops feeds one registered edge-detect flop, whose output is `level`.
  - `tick_rise` = new level AND NOT previous level. `tick_fall` is the converse.
  - Both ticks are registered outputs.
- **State machine.**
  - IDLE (after reset): waiting for the first `tick_rise`. No measurement is produced. On `tick_rise`, go to RUN with the counter cleared.
  - RUN: the counter increments every cycle.
    - On `tick_rise`: emit the measurement and restart the count.
    - If the counter reaches 2^CNT_BITS−1 with no edge: go to STALL and set `timeout`=1.
  - STALL: the counter holds. On `tick_rise`: clear `timeout`, go to RUN and restart the count. No measurement is emitted, because the interval is unknown.
- **Period arithmetic.** `period` = cycle index of this `tick_rise` minus cycle index of the previous one. Example: ticks at cycles 10 and 26 give 16. The result is unsigned and never wraps, because saturation diverts to STALL.
- **Handshake.**
  - A transfer occurs on a `clk_in` edge where `period_valid`=1 and `period_ready`=1.
  - `period` is stable while `period_valid`=1 and no new measurement arrives.
  - After a transfer with no new measurement, `period_valid`=0 on the next cycle.
  - New measurement in the same cycle as a transfer: `period_valid` stays 1, `period` takes the new value, and `overrun` is unchanged.
  - New measurement while `period_valid`=1 and `period_ready`=0: `period` is overwritten with the newer value, `period_valid` stays 1, and `overrun` is set to 1.
  - `overrun` clears only on `rst`.
- **Reset.**
  - Reset values: `level`, `tick_rise`, `tick_fall`, `period`, `period_valid`, `overrun` and `timeout` are all 0. The synchroniser chain is 0 and the state is IDLE.
  - Reset is honoured in any state, mid-count included. A partial interval is discarded.
  - If `slow_in` is high when reset is released, one `tick_rise` fires after the synchroniser latency. That pulse only arms RUN.

## Timing
- Latency: `slow_in` is first sampled high at `clk_in` edge k. `level` and `tick_rise` go to 1 after edge k+SYNC_STAGES and stay valid for exactly one cycle (the tick; `level` stays high).
- `period` and `period_valid` update on the same edge that asserts `tick_rise`, so they are visible in the same cycle as the tick.
- The minimum `slow_in` high or low time for guaranteed detection is SYNC_STAGES+1 `clk_in` cycles. Shorter pulses may be missed; this is not flagged.
- `timeout` asserts on the edge where the counter reaches all-ones, which is 2^CNT_BITS−1 cycles after the last `tick_rise`.
- `period_ready` has no combinational path to any output.

## Test plan
- **Steady toggling.** Apply reset, then toggle `slow_in` with 8 cycles high and 8 low, holding `period_ready`=1. Expect `tick_rise` every 16 cycles and `tick_fall` 8 cycles after each. The first `period_valid` pulse comes on the second `tick_rise` with `period`=16, and every rise after that gives 16. `overrun` and `timeout` stay 0.
- **Latency.** With SYNC_STAGES=2, raise `slow_in` before edge 100. Expect `tick_rise`=1 only in the cycle following edge 102, and `level`=1 from then on.
- **Back-pressure.** Hold `period_ready`=0 while periods of 16 then 20 are produced. Expect `period_valid` to stay 1, `period`=20, and `overrun`=1. Then raise `period_ready`: a single transfer occurs, `period_valid`=0 the next cycle, and `overrun` stays 1 until `rst`.
- **Simultaneous accept and new measurement.** Raise `period_ready` exactly on the cycle of a new `tick_rise`. Expect `period_valid` to remain 1 with the new value and `overrun`=0.
- **Timeout (CNT_BITS=6).** Stop toggling `slow_in` after a rise. Expect `timeout`=1 exactly 63 cycles after that `tick_rise`. On the next rise, `timeout`=0 and no measurement is emitted. The following rise, 16 cycles later, gives `period`=16.
- **Reset mid-measurement.** Assert `rst` for 1 cycle 5 cycles after a `tick_rise`. On the next cycle every output is 0. No measurement is produced by the first post-reset rise; the second rise produces the correct period.

Source files
------------

// File: rtl/clk_edge_meter.sv
// Synchronises a slow square wave into clk_in, emits rise/fall tick enables and
// measures the rising-edge period, delivered over a valid/ready handshake.
module clk_edge_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_BITS    = 26
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                slow_in,
    output logic                level,
    output logic                tick_rise,
    output logic                tick_fall,
    output logic [CNT_BITS-1:0] period,
    output logic                period_valid,
    input  logic                period_ready,
    output logic                overrun,
    output logic                timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_NEAR = {{(CNT_BITS-1){1'b1}}, 1'b0};
    localparam logic [CNT_BITS-1:0] CNT_ONE  = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   tick_rise_q, tick_rise_d;
    logic                   tick_fall_q, tick_fall_d;
    state_t                 state_q, state_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [CNT_BITS-1:0]    period_q, period_d;
    logic                   period_valid_q, period_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_q, timeout_d;
    logic                   rise;
    logic                   fall;
    logic                   meas;

    // Edge detect works on the next level so ticks and measurements land on the same edge
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], slow_in};
        level_d     = sync_q[SYNC_STAGES-1];
        rise        = level_d & ~level_q;
        fall        = ~level_d & level_q;
        tick_rise_d = rise;
        tick_fall_d = fall;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        meas      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_ZERO;
                end
            end
            S_RUN: begin
                if (rise) begin
                    meas  = 1'b1;
                    cnt_d = CNT_ZERO;
                end else if (cnt_q == CNT_NEAR) begin
                    cnt_d     = CNT_MAX;
                    state_d   = S_STALL;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_STALL: begin
                if (rise) begin
                    state_d   = S_RUN;
                    cnt_d     = CNT_ZERO;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // cnt_q counts cycles since the last rise minus one, so the period is cnt_q + 1
    always_comb begin
        period_d       = period_q;
        period_valid_d = period_valid_q;
        overrun_d      = overrun_q;
        if (meas) begin
            period_d       = cnt_q + CNT_ONE;
            period_valid_d = 1'b1;
            if (period_valid_q && !period_ready) begin
                overrun_d = 1'b1;
            end
        end else if (period_valid_q && period_ready) begin
            period_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_q         <= '0;
            level_q        <= 1'b0;
            tick_rise_q    <= 1'b0;
            tick_fall_q    <= 1'b0;
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            level_q        <= level_d;
            tick_rise_q    <= tick_rise_d;
            tick_fall_q    <= tick_fall_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign level        = level_q;
    assign tick_rise    = tick_rise_q;
    assign tick_fall    = tick_fall_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Directed bench for clk_edge_meter: tick timing, period scoreboard, back-pressure,
// overrun, timeout and reset behaviour with a 6-bit period counter.
module tb_clk_edge_meter;

    localparam int CW = 6;

    logic          clk_in;
    logic          rst;
    logic          slow_in;
    logic          level;
    logic          tick_rise;
    logic          tick_fall;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          period_ready;
    logic          overrun;
    logic          timeout;

    int checks;
    int errors;
    int exp_q[$];

    clk_edge_meter #(
        .SYNC_STAGES(2),
        .CNT_BITS   (CW)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .slow_in     (slow_in),
        .level       (level),
        .tick_rise   (tick_rise),
        .tick_fall   (tick_fall),
        .period      (period),
        .period_valid(period_valid),
        .period_ready(period_ready),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A transfer happens on the coming edge if valid and ready are both high now
    task automatic step();
        if (period_valid && period_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL xfer_unexpected: observed period %0d expected no transfer", period);
            end else begin
                int e;
                e = exp_q.pop_front();
                check_w("xfer_period", int'(period), e);
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    // Drive slow_in to val for n cycles; the tick is due on the third step
    task automatic phase(input logic val, input int n, input bit chk, input bit vld);
        slow_in = val;
        for (int i = 1; i <= n; i++) begin
            step();
            if (chk) begin
                check_b("tick_rise", tick_rise, val && (i == 3));
                check_b("tick_fall", tick_fall, !val && (i == 3));
                check_b("level", level, (i >= 3) ? val : !val);
                if (val && (i == 3)) check_b("vld_at_rise", period_valid, vld);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_level"}, level, 1'b0);
        check_b({tag, "_tick_rise"}, tick_rise, 1'b0);
        check_b({tag, "_tick_fall"}, tick_fall, 1'b0);
        check_w({tag, "_period"}, int'(period), 0);
        check_b({tag, "_valid"}, period_valid, 1'b0);
        check_b({tag, "_overrun"}, overrun, 1'b0);
        check_b({tag, "_timeout"}, timeout, 1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        slow_in      = 1'b0;
        period_ready = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;

        // Steady 8 high / 8 low; first rise only arms the measurement
        phase(1'b0, 8, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            if (p > 0) exp_q.push_back(16);
            phase(1'b1, 8, 1'b1, p > 0);
            phase(1'b0, 8, 1'b1, 1'b0);
        end
        check_b("steady_overrun", overrun, 1'b0);
        check_b("steady_timeout", timeout, 1'b0);

        // Back-pressure: 16 is overwritten by 20 and overrun latches
        period_ready = 1'b0;
        phase(1'b1, 8, 1'b1, 1'b1);
        check_w("bp_first_period", int'(period), 16);
        check_b("bp_first_overrun", overrun, 1'b0);
        phase(1'b0, 12, 1'b1, 1'b0);
        exp_q.push_back(20);
        phase(1'b1, 3, 1'b1, 1'b1);
        check_w("bp_period", int'(period), 20);
        check_b("bp_overrun", overrun, 1'b1);
        period_ready = 1'b1;
        step();
        check_b("bp_valid_after_xfer", period_valid, 1'b0);
        check_b("bp_overrun_sticky", overrun, 1'b1);
        phase(1'b1, 4, 1'b0, 1'b0);
        phase(1'b0, 8, 1'b1, 1'b0);

        // Reset five cycles after a rise
        exp_q.push_back(16);
        phase(1'b1, 7, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        phase(1'b1, 5, 1'b1, 1'b0);
        phase(1'b0, 8, 1'b1, 1'b0);
        exp_q.push_back(13);
        phase(1'b1, 8, 1'b1, 1'b1);
        check_b("postrst_overrun", overrun, 1'b0);

        // Accept of 16 coincides with arrival of 20
        period_ready = 1'b0;
        phase(1'b0, 8, 1'b1, 1'b0);
        exp_q.push_back(16);
        phase(1'b1, 8, 1'b1, 1'b1);
        phase(1'b0, 12, 1'b1, 1'b0);
        phase(1'b1, 2, 1'b1, 1'b0);
        period_ready = 1'b1;
        exp_q.push_back(20);
        step();
        check_b("sim_tick_rise", tick_rise, 1'b1);
        check_b("sim_valid", period_valid, 1'b1);
        check_w("sim_period", int'(period), 20);
        check_b("sim_overrun", overrun, 1'b0);
        phase(1'b1, 5, 1'b0, 1'b0);
        phase(1'b0, 8, 1'b1, 1'b0);

        // Timeout 63 cycles after the last rise
        exp_q.push_back(16);
        phase(1'b1, 3, 1'b1, 1'b1);
        for (int i = 1; i <= 63; i++) begin
            step();
            check_b("timeout_edge", timeout, i == 63);
        end
        phase(1'b1, 3, 1'b0, 1'b0);
        check_b("stall_timeout", timeout, 1'b1);
        check_b("stall_valid", period_valid, 1'b0);
        phase(1'b0, 8, 1'b1, 1'b0);
        phase(1'b1, 3, 1'b1, 1'b0);
        check_b("rearm_timeout", timeout, 1'b0);
        phase(1'b1, 5, 1'b0, 1'b0);
        phase(1'b0, 8, 1'b1, 1'b0);
        exp_q.push_back(16);
        phase(1'b1, 8, 1'b1, 1'b1);
        check_b("final_timeout", timeout, 1'b0);
        repeat (4) step();
        check_w("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
